rr_arb_mux: RTL and testbench
=============================

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 The block SHALL have parameter N, default 128, meaning data width per channel in bits (N >= 1).
REQ-002 The block SHALL have parameter CH, default 4, meaning the number of input channels (CH >= 2).
REQ-003 The block SHALL have derived local constant CHW = max(1, clog2(CH)), meaning the channel-index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, CH bits: per-channel beat valid.
REQ-007 The block SHALL have port in_data, input, CH*N bits: channel i data at bits [i*N +: N].
REQ-008 The block SHALL have port in_last, input, CH bits: per-channel end-of-packet marker.
REQ-009 The block SHALL have port in_ready, output, CH bits: per-channel beat accepted this cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit: output register holds a beat.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-012 The block SHALL have port out_data, output, N bits: registered selected data.
REQ-013 The block SHALL have port out_last, output, 1 bit: registered last marker.
REQ-014 The block SHALL have port out_ch, output, CHW bits: registered source-channel index.

Function
REQ-015 The block SHALL define load_en = !out_valid || out_ready; a beat transfers on a channel when in_valid[i] && in_ready[i].
REQ-016 In IDLE state the block SHALL grant the lowest-index valid channel at or after rr pointer ptr, searching cyclically and wrapping from CH-1 to 0.
REQ-017 The block SHALL assert in_ready only for the granted channel, only when load_en = 1, and for at most one channel per cycle.
REQ-018 On a transfer the block SHALL load out_data, out_last and out_ch from the granted channel and set out_valid = 1 on the next edge, giving 1-cycle latency.
REQ-019 The block SHALL clear out_valid when out_ready = 1 and no transfer occurs in the same cycle.
REQ-020 The block SHALL sustain one beat per cycle when out_ready stays high, with simultaneous drain and load.
REQ-021 The block SHALL hold out_data, out_last and out_ch stable while out_valid = 1 and out_ready = 0.
REQ-022 A transfer with in_last = 0 SHALL move the state machine IDLE -> LOCKED(ch) and record the channel.
REQ-023 In LOCKED the block SHALL grant only the locked channel; other channels see in_ready = 0 even when that channel is idle.
REQ-024 A transfer with in_last = 1 SHALL return the state machine to IDLE and set ptr = (granted + 1) mod CH.
REQ-025 A single-beat packet (in_last = 1 on its first beat) SHALL stay in IDLE and advance ptr.
REQ-026 The block SHALL leave ptr and state unchanged when no channel is valid.

Reset
REQ-027 rst_n low SHALL asynchronously force out_valid = 0, out_data = 0, out_last = 0, out_ch = 0, ptr = 0 and state = IDLE.
REQ-028 The block SHALL hold in_ready = 0 while rst_n is low.
REQ-029 Reset deassertion mid-packet SHALL resume in IDLE, and any partial packet is discarded upstream's concern.

Structure
REQ-030 The IDLE/LOCKED state encoding and the CHW clog2 helper SHALL reside in shared package mux_pkg.
REQ-031 Cyclic priority selection SHALL be the sub-module rr_arbiter (inputs req[CH] and ptr; outputs one-hot gnt and gnt_idx), which is combinational and reusable.

Verification
REQ-032 The bench SHALL check: CH=4, N=8, all valid and last = 1, data = 0x10/0x11/0x12/0x13, out_ready = 1 -> out_ch sequence 0,1,2,3,0 with out_data matching, one beat per cycle.
REQ-033 The bench SHALL check: ch1 sends a 3-beat packet (last on beat 3) while ch2 is valid -> ch2 is not granted until the cycle after ch1's last beat transfers.
REQ-034 The bench SHALL check: out_ready = 0 for 5 cycles with out_valid = 1 -> out_data stable and in_ready = 0000 throughout.
REQ-035 The bench SHALL check: only ch3 valid with ptr = 0 -> ch3 is granted, then ptr = 0, demonstrating wrap-around.
REQ-036 The bench SHALL check: rst_n asserted while LOCKED on ch2 with out_valid = 1 -> all outputs are 0 immediately, and after release ch0 is granted first.
REQ-037 The bench SHALL check: out_ready toggles 1,0,1,0 with continuous input -> no beat is lost or duplicated, confirmed by a scoreboard.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin arbitrating packet mux.
package mux_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // Channel-index width: clog2(ch), but never below one bit.
   function automatic int chw_f(input int ch);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < ch) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational cyclic-priority arbiter: grants the first requester at or after ptr.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int CH  = 4,
   localparam int CHW = chw_f(CH)
) (
   input  logic [CH-1:0]  req,
   input  logic [CHW-1:0] ptr,
   output logic [CH-1:0]  gnt,
   output logic [CHW-1:0] gnt_idx
);

   // Walk offsets from farthest to nearest so the nearest requester overwrites the rest.
   always_comb begin
      int idx;
      gnt     = '0;
      gnt_idx = '0;
      idx     = 0;
      for (int off = CH - 1; off >= 0; off--) begin
         idx = (int'(ptr) + off) % CH;
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            gnt_idx  = CHW'(idx);
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin packet mux: CH input channels into one registered output stage,
// holding the grant on a channel until its last beat has transferred.
module rr_arb_mux
   import mux_pkg::*;
#(
   parameter  int N   = 128,
   parameter  int CH  = 4,
   localparam int CHW = chw_f(CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [CH-1:0]   in_valid,
   input  logic [CH*N-1:0] in_data,
   input  logic [CH-1:0]   in_last,
   output logic [CH-1:0]   in_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    out_data,
   output logic            out_last,
   output logic [CHW-1:0]  out_ch
);

   state_t         state_q, state_d;
   logic [CHW-1:0] ptr_q, ptr_d;
   logic [CHW-1:0] lock_q, lock_d;
   logic           out_valid_q, out_valid_d;
   logic [N-1:0]   out_data_q, out_data_d;
   logic           out_last_q, out_last_d;
   logic [CHW-1:0] out_ch_q, out_ch_d;

   logic [CH-1:0]  arb_req;
   logic [CHW-1:0] arb_ptr;
   logic [CH-1:0]  arb_gnt;
   logic [CHW-1:0] gnt_idx;
   logic           load_en;
   logic           xfer;

   // While locked, only the locked channel may request.
   always_comb begin
      arb_req = in_valid;
      arb_ptr = ptr_q;
      if (state_q == ST_LOCKED) begin
         arb_req = in_valid & (CH'(1) << lock_q);
         arb_ptr = lock_q;
      end
   end

   rr_arbiter #(
      .CH (CH)
   ) u_arb (
      .req     (arb_req),
      .ptr     (arb_ptr),
      .gnt     (arb_gnt),
      .gnt_idx (gnt_idx)
   );

   assign load_en  = !out_valid_q || out_ready;
   assign in_ready = (load_en && rst_n) ? arb_gnt : '0;
   assign xfer     = |in_ready;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      lock_d      = lock_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_ch_d    = out_ch_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[int'(gnt_idx)*N +: N];
         out_last_d  = in_last[gnt_idx];
         out_ch_d    = gnt_idx;
         if (in_last[gnt_idx]) begin
            state_d = ST_IDLE;
            ptr_d   = (int'(gnt_idx) == CH - 1) ? '0 : CHW'(gnt_idx + 1'b1);
         end else begin
            state_d = ST_LOCKED;
            lock_d  = gnt_idx;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         lock_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_ch_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         lock_q      <= lock_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_ch_q    <= out_ch_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux (CH=4, N=8) with hand-computed expectations.
module tb_rr_arb_mux;

   localparam int N   = 8;
   localparam int CH  = 4;
   localparam int CHW = 2;

   logic            clk;
   logic            rst_n;
   logic [CH-1:0]   in_valid;
   logic [CH*N-1:0] in_data;
   logic [CH-1:0]   in_last;
   logic [CH-1:0]   in_ready;
   logic            out_valid;
   logic            out_ready;
   logic [N-1:0]    out_data;
   logic            out_last;
   logic [CHW-1:0]  out_ch;

   int cmp_cnt = 0;
   int err_cnt = 0;

   logic [15:0] sb_q[$];
   logic [15:0] sb_item;
   int          push_cnt;
   int          pop_cnt;
   int          order[4];

   rr_arb_mux #(
      .N  (N),
      .CH (CH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ch    (out_ch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp)
      else begin
         err_cnt++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
      in_data = {d3, d2, d1, d0};
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 4'hF;
      in_last   = 4'hF;
      out_ready = 1'b1;
      set_data(8'h00, 8'h00, 8'h00, 8'h00);

      // Reset state, with requests present
      tick();
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data", 32'(out_data), 32'h0);
      check("rst_out_last", 32'(out_last), 32'h0);
      check("rst_out_ch", 32'(out_ch), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h0);
      in_valid = 4'h0;
      #2 rst_n = 1'b1;
      tick();

      // Round robin over four single-beat channels, one beat per cycle
      in_valid = 4'hF;
      in_last  = 4'hF;
      set_data(8'h10, 8'h11, 8'h12, 8'h13);
      #1;
      for (int k = 0; k < 5; k++) begin
         check("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
         tick();
         check("rr_out_valid", 32'(out_valid), 32'h1);
         check("rr_out_ch", 32'(out_ch), 32'(k % 4));
         check("rr_out_data", 32'(out_data), 32'(8'h10 + k % 4));
         check("rr_out_last", 32'(out_last), 32'h1);
      end
      in_valid = 4'h0;
      tick();
      check("drain1_valid", 32'(out_valid), 32'h0);

      // ptr=1: ch1 sends three beats while ch2 waits
      in_valid = 4'b0110;
      in_last  = 4'b0100;
      set_data(8'h00, 8'h21, 8'h30, 8'h00);
      #1;
      check("pkt_b1_ready", 32'(in_ready), 32'b0010);
      tick();
      check("pkt_b1_ch", 32'(out_ch), 32'h1);
      check("pkt_b1_data", 32'(out_data), 32'h21);
      check("pkt_b1_last", 32'(out_last), 32'h0);
      in_valid = 4'b0100;
      #1;
      check("pkt_gap_ready", 32'(in_ready), 32'b0000);
      tick();
      check("pkt_gap_valid", 32'(out_valid), 32'h0);
      in_valid = 4'b0110;
      set_data(8'h00, 8'h22, 8'h30, 8'h00);
      #1;
      check("pkt_b2_ready", 32'(in_ready), 32'b0010);
      tick();
      check("pkt_b2_data", 32'(out_data), 32'h22);
      in_last = 4'b0110;
      set_data(8'h00, 8'h23, 8'h30, 8'h00);
      #1;
      check("pkt_b3_ready", 32'(in_ready), 32'b0010);
      tick();
      check("pkt_b3_data", 32'(out_data), 32'h23);
      check("pkt_b3_last", 32'(out_last), 32'h1);
      in_valid = 4'b0100;
      #1;
      check("pkt_ch2_ready", 32'(in_ready), 32'b0100);
      tick();
      check("pkt_ch2_ch", 32'(out_ch), 32'h2);
      check("pkt_ch2_data", 32'(out_data), 32'h30);
      in_valid = 4'h0;
      tick();
      check("drain2_valid", 32'(out_valid), 32'h0);

      // ptr=3, only ch0 valid: wraps to ch0, then stall for five cycles
      in_valid = 4'b0001;
      in_last  = 4'hF;
      set_data(8'h40, 8'h41, 8'h42, 8'h43);
      #1;
      check("stall_load_ready", 32'(in_ready), 32'b0001);
      tick();
      out_ready = 1'b0;
      in_valid  = 4'hF;
      set_data(8'h44, 8'h45, 8'h46, 8'h47);
      for (int k = 0; k < 5; k++) begin
         #1;
         check("stall_in_ready", 32'(in_ready), 32'h0);
         tick();
         check("stall_valid", 32'(out_valid), 32'h1);
         check("stall_data", 32'(out_data), 32'h40);
         check("stall_ch", 32'(out_ch), 32'h0);
      end
      in_valid  = 4'h0;
      out_ready = 1'b1;
      tick();
      check("drain3_valid", 32'(out_valid), 32'h0);

      // ptr=1: ch3 alone twice; second grant happens from ptr=0 and wraps back
      in_valid = 4'b1000;
      set_data(8'h50, 8'h51, 8'h52, 8'h53);
      #1;
      check("wrap1_ready", 32'(in_ready), 32'b1000);
      tick();
      check("wrap1_ch", 32'(out_ch), 32'h3);
      set_data(8'h50, 8'h51, 8'h52, 8'h54);
      #1;
      check("wrap2_ready", 32'(in_ready), 32'b1000);
      tick();
      check("wrap2_ch", 32'(out_ch), 32'h3);
      check("wrap2_data", 32'(out_data), 32'h54);
      in_valid = 4'hF;
      #1;
      check("wrap_ptr0_ready", 32'(in_ready), 32'b0001);

      // Lock on ch2, then reset asynchronously mid-packet
      in_valid = 4'b0100;
      in_last  = 4'b0000;
      set_data(8'h60, 8'h61, 8'h62, 8'h63);
      #1;
      check("lock_ready", 32'(in_ready), 32'b0100);
      tick();
      check("lock_ch", 32'(out_ch), 32'h2);
      check("lock_valid", 32'(out_valid), 32'h1);
      out_ready = 1'b0;
      in_valid  = 4'hF;
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'h0);
      check("arst_data", 32'(out_data), 32'h0);
      check("arst_ch", 32'(out_ch), 32'h0);
      check("arst_last", 32'(out_last), 32'h0);
      check("arst_in_ready", 32'(in_ready), 32'h0);
      in_last = 4'hF;
      set_data(8'h10, 8'h11, 8'h12, 8'h13);
      out_ready = 1'b1;
      #1 rst_n = 1'b1;
      #1;
      check("post_rst_ready", 32'(in_ready), 32'b0001);
      tick();
      check("post_rst_ch", 32'(out_ch), 32'h0);
      check("post_rst_data", 32'(out_data), 32'h10);
      in_valid = 4'h0;
      tick();
      check("drain4_valid", 32'(out_valid), 32'h0);

      // ptr=1, out_ready toggling with all channels streaming single beats
      order    = '{1, 2, 3, 0};
      push_cnt = 0;
      pop_cnt  = 0;
      in_valid = 4'hF;
      in_last  = 4'hF;
      for (int k = 0; k < 8; k++) begin
         out_ready = (k % 2 == 0);
         set_data(8'h80 + 8'(k), 8'h90 + 8'(k), 8'hA0 + 8'(k), 8'hB0 + 8'(k));
         #1;
         check("tog_in_ready", 32'(in_ready),
               (k % 2 == 0) ? 32'(4'b0001 << order[k/2]) : 32'h0);
         for (int i = 0; i < CH; i++) begin
            if (in_ready[i]) begin
               sb_q.push_back({8'(i), in_data[i*N +: N]});
               push_cnt++;
            end
         end
         if (out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'h1);
            if (sb_q.size() != 0) begin
               sb_item = sb_q.pop_front();
               pop_cnt++;
               check("sb_ch", 32'(out_ch), 32'(sb_item[15:8]));
               check("sb_data", 32'(out_data), 32'(sb_item[7:0]));
            end
         end
         tick();
      end
      in_valid  = 4'h0;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (out_valid) begin
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'h1);
            if (sb_q.size() != 0) begin
               sb_item = sb_q.pop_front();
               pop_cnt++;
               check("sb_ch", 32'(out_ch), 32'(sb_item[15:8]));
               check("sb_data", 32'(out_data), 32'(sb_item[7:0]));
            end
         end
         tick();
         if (!out_valid) break;
      end
      check("sb_drained", 32'(out_valid), 32'h0);
      check("sb_push_cnt", 32'(push_cnt), 32'd4);
      check("sb_pop_cnt", 32'(pop_cnt), 32'd4);
      check("sb_left", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
